// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: size encodings,
// FSM state type and the wait-state ceiling.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam int         MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the MEM-stage requester
// and the data memory responder.
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output mem_read, mem_write, size, load_unsigned, addr, wdata,
        input  rdata, busy, done, misaligned
    );

    modport slave (
        input  mem_read, mem_write, size, load_unsigned, addr, wdata,
        output rdata, busy, done, misaligned
    );
endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Big-endian byte/half/word select with sign or zero extension; b0 is the
// byte at the access address, b3 the byte three above it.
module load_extend
    import dmem_pkg::*;
(
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    // Size-dependent extension of the fetched bytes
    always_comb begin
        result = {b0, b1, b2, b3};
        case (size)
            SZ_BYTE: result = load_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
            SZ_HALF: result = load_unsigned ? {16'd0, b0, b1} : {{16{b0[7]}}, b0, b1};
            default: result = {b0, b1, b2, b3};
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle big-endian data memory for LW/LH/LB(U)/SW/SH/SB requests.
// Optional DMEM_ALIGN_CHECK_EN flags (and suppresses) misaligned half/word accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int WAIT_CLAMP = (WAIT_CYCLES < 1) ? 1 :
                                ((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CLAMP);

    dmem_state_t state_r, state_s;
    logic [3:0]    cnt_r;
    logic          op_write_r;
    logic [1:0]    size_r;
    logic          uns_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rdata_r;
    logic          busy_r, done_r, mis_r;
    logic [7:0]    mem_r [0:DEPTH-1];

    logic          req_s, access_s, we_s, ld_s, mis_s;
    logic [AW-1:0] a0_s, a1_s, a2_s, a3_s;
    logic [31:0]   ld_val_s;

    assign req_s = bus.mem_read | bus.mem_write;

    // Alignment decision and effective base address of the latched request
    always_comb begin
        a0_s  = addr_r;
        mis_s = 1'b0;
        case (size_r)
            SZ_BYTE: a0_s = addr_r;
`ifdef DMEM_ALIGN_CHECK_EN
            SZ_HALF: mis_s = addr_r[0];
            default: mis_s = (addr_r[1:0] != 2'b00);
`else
            SZ_HALF: a0_s = {addr_r[AW-1:1], 1'b0};
            default: a0_s = {addr_r[AW-1:2], 2'b00};
`endif
        endcase
    end

    // Byte lanes wrap naturally because the index is exactly AW bits wide
    assign a1_s = a0_s + AW'(1);
    assign a2_s = a0_s + AW'(2);
    assign a3_s = a0_s + AW'(3);

    load_extend u_load_extend (
        .b0            (mem_r[a0_s]),
        .b1            (mem_r[a1_s]),
        .b2            (mem_r[a2_s]),
        .b3            (mem_r[a3_s]),
        .size          (size_r),
        .load_unsigned (uns_r),
        .result        (ld_val_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) state_s = WAIT;
                else       state_s = IDLE;
            end
            WAIT: begin
                if (cnt_r == 4'd1) state_s = RESP;
                else               state_s = WAIT;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode: the access happens on the last wait edge
    always_comb begin
        access_s = 1'b0;
        we_s     = 1'b0;
        ld_s     = 1'b0;
        if (state_r == WAIT && cnt_r == 4'd1) begin
            access_s = 1'b1;
            we_s     = op_write_r & ~mis_s;
            ld_s     = ~op_write_r & ~mis_s;
        end else begin
            access_s = 1'b0;
        end
    end

    // Request capture, wait counter and registered response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= 4'd0;
            op_write_r <= 1'b0;
            size_r     <= SZ_BYTE;
            uns_r      <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            rdata_r    <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mis_r      <= 1'b0;
        end else begin
            if (state_r == IDLE && req_s) begin
                cnt_r      <= WAIT_LD;
                op_write_r <= bus.mem_write;
                size_r     <= bus.size;
                uns_r      <= bus.load_unsigned;
                addr_r     <= bus.addr[AW-1:0];
                wdata_r    <= bus.wdata;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (ld_s) rdata_r <= ld_val_s;
            busy_r <= (state_s != IDLE);
            done_r <= access_s;
            mis_r  <= access_s & mis_s;
        end
    end

    // Storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            case (size_r)
                SZ_BYTE: mem_r[a0_s] <= wdata_r[7:0];
                SZ_HALF: begin
                    mem_r[a0_s] <= wdata_r[15:8];
                    mem_r[a1_s] <= wdata_r[7:0];
                end
                default: begin
                    mem_r[a0_s] <= wdata_r[31:24];
                    mem_r[a1_s] <= wdata_r[23:16];
                    mem_r[a2_s] <= wdata_r[15:8];
                    mem_r[a3_s] <= wdata_r[7:0];
                end
            endcase
        end
    end

    assign bus.rdata      = rdata_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.misaligned = mis_r;

endmodule
